// File: rtl/game_clock_n.sv
// N-player round-robin game clock with a shared 1 Hz prescaler.
// Define GAME_CLOCK_INCREMENT_EN to add a saturating per-move Fischer increment.
module game_clock_n #(
    parameter int p_players = 2,
    parameter int p_divider = 50_000_000,
    parameter int p_time_w  = 16,
    parameter int p_incr_w  = 8
) (
    input  logic                            i_clk_50m,
    input  logic                            i_rst,
    input  logic [p_players-1:0]            i_click,
    input  logic                            i_stop,
    input  logic                            i_restart,
    input  logic [p_time_w-1:0]             i_init_sec,
    input  logic [p_incr_w-1:0]             i_incr_sec,
    output logic [p_players*p_time_w-1:0]   o_time,
    output logic [p_players-1:0]            o_active,
    output logic [p_players-1:0]            o_loser,
    output logic [1:0]                      o_state,
    output logic                            o_tick
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    localparam int PW = (p_divider > 2) ? $clog2(p_divider) : 1;
    localparam logic [PW-1:0]       PRESC_LAST = PW'(p_divider - 1);
    localparam logic [p_time_w-1:0] LANE_ONE   = {{(p_time_w-1){1'b0}}, 1'b1};
    localparam logic [p_time_w-1:0] LANE_ZERO  = {p_time_w{1'b0}};
    localparam logic [p_players-1:0] FIRST_PLAYER = {{(p_players-1){1'b0}}, 1'b1};

    state_t                               state_q, state_d;
    logic [p_players-1:0][p_time_w-1:0]   time_q, time_d;
    logic [p_players-1:0]                 active_q, active_d;
    logic [p_players-1:0]                 loser_q, loser_d;
    logic [PW-1:0]                        presc_q, presc_d;
    logic                                 tick_q, tick_d;

    logic                                 click_ok_s;
    logic                                 term_s;
    logic [p_time_w-1:0]                  act_time_s;
    logic [p_players-1:0]                 next_active_s;

`ifdef GAME_CLOCK_INCREMENT_EN
    function automatic logic [p_time_w-1:0] sat_add(
        input logic [p_time_w-1:0] a,
        input logic [p_incr_w-1:0] b
    );
        logic [p_time_w:0] sum;
        sum = {1'b0, a} + (p_time_w+1)'(b);
        if (sum[p_time_w]) begin
            sat_add = {p_time_w{1'b1}};
        end else begin
            sat_add = sum[p_time_w-1:0];
        end
    endfunction
`else
    logic unused_incr_s;
    assign unused_incr_s = ^i_incr_sec;
`endif

    // Turn decode: accepted click, terminal count, running lane value, next player.
    always_comb begin
        click_ok_s    = |(i_click & active_q);
        term_s        = (presc_q == PRESC_LAST);
        next_active_s = {active_q[p_players-2:0], active_q[p_players-1]};
        act_time_s    = LANE_ZERO;
        for (int k = 0; k < p_players; k++) begin
            if (active_q[k]) begin
                act_time_s = act_time_s | time_q[k];
            end else begin
                act_time_s = act_time_s;
            end
        end
    end

    // Next-state logic; priority is restart, stop, click, tick.
    always_comb begin
        state_d  = state_q;
        time_d   = time_q;
        active_d = active_q;
        loser_d  = loser_q;
        presc_d  = presc_q;
        tick_d   = 1'b0;
        if (i_restart) begin
            state_d  = ST_IDLE;
            time_d   = {p_players{i_init_sec}};
            active_d = FIRST_PLAYER;
            loser_d  = {p_players{1'b0}};
            presc_d  = {PW{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (click_ok_s) begin
                        state_d  = ST_RUN;
                        active_d = next_active_s;
                        presc_d  = {PW{1'b0}};
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (i_stop) begin
                        state_d = ST_PAUSE;
                    end else if (click_ok_s) begin
                        active_d = next_active_s;
                        presc_d  = {PW{1'b0}};
`ifdef GAME_CLOCK_INCREMENT_EN
                        for (int k = 0; k < p_players; k++) begin
                            if (active_q[k]) begin
                                time_d[k] = sat_add(time_q[k], i_incr_sec);
                            end else begin
                                time_d[k] = time_q[k];
                            end
                        end
`endif
                    end else if (term_s) begin
                        presc_d = {PW{1'b0}};
                        // A lane already at zero ends the game without wrapping.
                        if (act_time_s == LANE_ZERO) begin
                            state_d = ST_OVER;
                            loser_d = active_q;
                        end else begin
                            tick_d = 1'b1;
                            for (int k = 0; k < p_players; k++) begin
                                if (active_q[k]) begin
                                    time_d[k] = time_q[k] - LANE_ONE;
                                end else begin
                                    time_d[k] = time_q[k];
                                end
                            end
                            if (act_time_s == LANE_ONE) begin
                                state_d = ST_OVER;
                                loser_d = active_q;
                            end else begin
                                state_d = ST_RUN;
                            end
                        end
                    end else begin
                        presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
                    end
                end
                ST_PAUSE: begin
                    if (i_stop) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_OVER: begin
                    state_d = ST_OVER;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk_50m) begin
        if (!i_rst) begin
            state_q  <= ST_IDLE;
            time_q   <= {p_players{i_init_sec}};
            active_q <= FIRST_PLAYER;
            loser_q  <= {p_players{1'b0}};
            presc_q  <= {PW{1'b0}};
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            time_q   <= time_d;
            active_q <= active_d;
            loser_q  <= loser_d;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
        end
    end

    assign o_time   = time_q;
    assign o_active = active_q;
    assign o_loser  = loser_q;
    assign o_state  = state_q;
    assign o_tick   = tick_q;

endmodule
